// File: rtl/mod20_pkg.sv
// Shared constants for the mod-20 count bus receiver: widths, direction codes,
// wrap helpers and the active-high 7-segment glyph table.
package mod20_pkg;

    localparam int MOD_N = 20;
    localparam int CNT_W = 5;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOD_N - 1);

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10,
        DIR_JUMP = 2'b11
    } dir_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Segment order {g,f,e,d,c,b,a}; codes 10..15 are padded blank so a raw
    // 4-bit BCD index can never select outside the table.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [CNT_W-1:0] mod_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_LAST) ? '0 : v + 5'd1;
    endfunction

    function automatic logic [CNT_W-1:0] mod_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_LAST : v - 5'd1;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD to active-high 7-segment glyph, with a blanking override.
module seg7_encode
    import mod20_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            seg = SEG_TABLE[bcd];
        end
    end

endmodule

// File: rtl/mod20_display_decoder.sv
// Receives the mod-20 count bus, classifies each change and scans the value
// onto a two-digit multiplexed 7-segment display.
module mod20_display_decoder
    import mod20_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic             clk_50M,
    input  logic             reset,
    input  logic [CNT_W-1:0] count_in,
    output logic [6:0]       seg,
    output logic [1:0]       an,
    output logic             dp,
    output logic [1:0]       dir,
    output logic             step_pulse,
    output logic             range_err
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0] AN_OFF  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

    logic [CNT_W-1:0] count_q_reg;
    logic [CNT_W-1:0] cur_q_reg;
    logic             have_hist_reg;
    dir_t             dir_reg;
    logic             step_pulse_reg;
    logic             range_err_reg;

    logic [RW-1:0]    refresh_reg;
    logic             digit_sel_reg;
    logic [6:0]       seg_reg;
    logic [1:0]       an_reg;
    logic             dp_reg;

    logic             tens;
    logic [3:0]       units;
    logic [6:0]       glyph;

    // Plain input sample stage; reset is irrelevant because the check stage
    // ignores count_q while reset is held.
    always_ff @(posedge clk_50M) begin
        count_q_reg <= count_in;
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            cur_q_reg      <= '0;
            have_hist_reg  <= 1'b0;
            dir_reg        <= DIR_NONE;
            step_pulse_reg <= 1'b0;
            range_err_reg  <= 1'b0;
        end else begin
            step_pulse_reg <= 1'b0;
            if (count_q_reg > CNT_LAST) begin
                range_err_reg <= 1'b1;
            end else if (!have_hist_reg) begin
                // First legal sample only seeds history; there is no prior value to compare.
                cur_q_reg     <= count_q_reg;
                have_hist_reg <= 1'b1;
            end else if (count_q_reg != cur_q_reg) begin
                cur_q_reg      <= count_q_reg;
                step_pulse_reg <= 1'b1;
                if (count_q_reg == mod_inc(cur_q_reg)) begin
                    dir_reg <= DIR_UP;
                end else if (count_q_reg == mod_dec(cur_q_reg)) begin
                    dir_reg <= DIR_DOWN;
                end else begin
                    dir_reg <= DIR_JUMP;
                end
            end
        end
    end

    always_comb begin
        tens  = (cur_q_reg >= 5'd10);
        units = tens ? 4'(cur_q_reg - 5'd10) : cur_q_reg[3:0];
    end

    seg7_encode u_seg7 (
        .bcd   (digit_sel_reg ? {3'b000, tens} : units),
        .blank (digit_sel_reg && !tens),
        .seg   (glyph)
    );

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            refresh_reg   <= '0;
            digit_sel_reg <= 1'b0;
            seg_reg       <= SEG_OFF;
            an_reg        <= AN_OFF;
            dp_reg        <= DP_OFF;
        end else begin
            if (refresh_reg == REFRESH_LAST) begin
                refresh_reg   <= '0;
                digit_sel_reg <= ~digit_sel_reg;
            end else begin
                refresh_reg <= refresh_reg + 1'b1;
            end
            seg_reg <= glyph ^ {7{SEG_ACTIVE_LOW}};
            an_reg  <= (digit_sel_reg ? 2'b10 : 2'b01) ^ {2{SEG_ACTIVE_LOW}};
            dp_reg  <= (!digit_sel_reg && range_err_reg) ^ SEG_ACTIVE_LOW;
        end
    end

    assign seg        = seg_reg;
    assign an         = an_reg;
    assign dp         = dp_reg;
    assign dir        = dir_reg;
    assign step_pulse = step_pulse_reg;
    assign range_err  = range_err_reg;

endmodule

// File: tb/tb_mod20_display_decoder.sv
// Directed vector bench for the mod-20 display decoder, run with a 4-cycle scan slot.
module tb_mod20_display_decoder;

    logic       clk_50M = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] count_in = 5'd0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       dp;
    logic [1:0] dir;
    logic       step_pulse;
    logic       range_err;

    int total = 0;
    int bad = 0;

    logic [6:0] seg_hi [10];

    typedef struct {
        logic [4:0] val;
        logic [1:0] edir;
        int         tens;
        int         units;
    } vec_t;

    vec_t vecs [26];

    mod20_display_decoder #(
        .REFRESH_DIV    (4),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk_50M    (clk_50M),
        .reset      (reset),
        .count_in   (count_in),
        .seg        (seg),
        .an         (an),
        .dp         (dp),
        .dir        (dir),
        .step_pulse (step_pulse),
        .range_err  (range_err)
    );

    always #5 clk_50M = ~clk_50M;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_50M);
        #1;
    endtask

    task automatic check_display(input string name, input int tens, input int units, input logic err);
        int n;
        logic [6:0] e;
        n = 0;
        while (an !== 2'b10 && n < 20) begin
            tick;
            n++;
        end
        chk({name, "_units_an"}, 32'(an), 32'h2);
        e = ~seg_hi[units];
        chk({name, "_units_seg"}, 32'(seg), 32'(e));
        chk({name, "_units_dp"}, 32'(dp), err ? 32'h0 : 32'h1);
        n = 0;
        while (an !== 2'b01 && n < 20) begin
            tick;
            n++;
        end
        chk({name, "_tens_an"}, 32'(an), 32'h1);
        e = (tens != 0) ? ~seg_hi[1] : 7'h7F;
        chk({name, "_tens_seg"}, 32'(seg), 32'(e));
        chk({name, "_tens_dp"}, 32'(dp), 32'h1);
    endtask

    task automatic apply_step(input string name, input logic [4:0] val, input logic [1:0] edir);
        count_in = val;
        tick;
        chk({name, "_early_pulse"}, 32'(step_pulse), 0);
        tick;
        chk({name, "_pulse"}, 32'(step_pulse), 1);
        chk({name, "_dir"}, 32'(dir), 32'(edir));
        tick;
        chk({name, "_pulse_end"}, 32'(step_pulse), 0);
        repeat (4) tick;
    endtask

    task automatic check_off(input string name);
        chk({name, "_seg"}, 32'(seg), 32'h7F);
        chk({name, "_an"}, 32'(an), 32'h3);
        chk({name, "_dp"}, 32'(dp), 1);
        chk({name, "_dir"}, 32'(dir), 0);
        chk({name, "_pulse"}, 32'(step_pulse), 0);
        chk({name, "_err"}, 32'(range_err), 0);
    endtask

    initial begin
        logic [1:0] exp_an;
        logic [6:0] exp_seg;
        seg_hi = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

        for (int i = 1; i <= 19; i++) begin
            vecs[i-1] = '{val: 5'(i), edir: 2'b01, tens: i / 10, units: i % 10};
        end
        vecs[19] = '{val: 5'd0,  edir: 2'b01, tens: 0, units: 0};
        vecs[20] = '{val: 5'd1,  edir: 2'b01, tens: 0, units: 1};
        vecs[21] = '{val: 5'd0,  edir: 2'b10, tens: 0, units: 0};
        vecs[22] = '{val: 5'd19, edir: 2'b10, tens: 1, units: 9};
        vecs[23] = '{val: 5'd5,  edir: 2'b11, tens: 0, units: 5};
        vecs[24] = '{val: 5'd12, edir: 2'b11, tens: 1, units: 2};
        vecs[25] = '{val: 5'd7,  edir: 2'b11, tens: 0, units: 7};

        // Reset for one edge with the bus at 0.
        tick;
        check_off("reset");
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick;
            exp_an  = ((((k - 1) / 4) % 2) == 0) ? 2'b10 : 2'b01;
            exp_seg = (exp_an == 2'b10) ? 7'h40 : 7'h7F;
            chk("idle_an", 32'(an), 32'(exp_an));
            chk("idle_seg", 32'(seg), 32'(exp_seg));
            chk("idle_pulse", 32'(step_pulse), 0);
            chk("idle_dir", 32'(dir), 0);
        end
        $display("idle scan checked for 16 cycles");

        for (int v = 0; v < 26; v++) begin
            apply_step("step", vecs[v].val, vecs[v].edir);
            check_display("disp", vecs[v].tens, vecs[v].units, 1'b0);
            $display("vec %0d: count=%0d dir=%b tens=%0d units=%0d", v, vecs[v].val, vecs[v].edir,
                     vecs[v].tens, vecs[v].units);
        end

        // Out-of-range value held for three cycles while showing 7.
        count_in = 5'd25;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (i >= 1) chk("oor_err", 32'(range_err), 1);
            chk("oor_pulse", 32'(step_pulse), 0);
            chk("oor_dir", 32'(dir), 32'h3);
            exp_seg = (an == 2'b10) ? ~seg_hi[7] : 7'h7F;
            chk("oor_seg", 32'(seg), 32'(exp_seg));
        end
        apply_step("oor_to_8", 5'd8, 2'b01);
        chk("oor_err_sticky", 32'(range_err), 1);
        check_display("oor_disp", 0, 8, 1'b1);
        $display("range sequence: 25 x3 then 8, range_err=%0b", range_err);

        // Reset partway through a tens slot.
        begin
            int n;
            n = 0;
            while (an !== 2'b01 && n < 20) begin
                tick;
                n++;
            end
            chk("mid_wait_tens", 32'(an), 32'h1);
        end
        tick;
        reset = 1'b1;
        tick;
        check_off("midreset");
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick;
            chk("restart_an", 32'(an), (k <= 4) ? 32'h2 : 32'h1);
            chk("restart_pulse", 32'(step_pulse), 0);
        end
        chk("restart_err", 32'(range_err), 0);
        $display("mid-scan reset and restart checked");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
